// File: rtl/regfile_issue_ctrl_pkg.sv
// Shared types and constants for the register-file issue controller.
package regfile_issue_ctrl_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OPND  = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, with writeback
// bypass on the two hazard lookups so a retiring write never stalls a reader.
module regfile_scoreboard #(
    parameter int unsigned AWIDTH = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              set_en_i,
    input  logic [AWIDTH-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [AWIDTH-1:0] clr_addr_i,
    input  logic              rs_use_i,
    input  logic [AWIDTH-1:0] rs_addr_i,
    input  logic              rt_use_i,
    input  logic [AWIDTH-1:0] rt_addr_i,
    output logic              rs_hazard_o,
    output logic              rt_hazard_o
);

    localparam int unsigned NREG = 1 << AWIDTH;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so an issue to the retiring register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
        if (set_en_i) busy_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clear) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign rs_hazard_o = rs_use_i & busy_q[rs_addr_i] & ~(clr_en_i & (clr_addr_i == rs_addr_i));
    assign rt_hazard_o = rt_use_i & busy_q[rt_addr_i] & ~(clr_en_i & (clr_addr_i == rt_addr_i));

endmodule

// File: rtl/regfile_issue_ctrl.sv
// Register-file issue controller: accepts decoded instructions, stalls on RAW
// hazards, reads operands from the register file and hands them to execute.
module regfile_issue_ctrl
    import regfile_issue_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AWIDTH-1:0] in_rs,
    input  logic              in_use_rs,
    input  logic [AWIDTH-1:0] in_rt,
    input  logic              in_use_rt,
    input  logic [AWIDTH-1:0] in_rd,
    input  logic              in_use_rd,
    input  logic              wb_valid,
    input  logic [AWIDTH-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [AWIDTH-1:0] rf_addr_rs,
    output logic              rf_req_rs,
    output logic [AWIDTH-1:0] rf_addr_rt,
    output logic              rf_req_rt,
    output logic [AWIDTH-1:0] rf_addr_rd,
    output logic              rf_req_rd,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rs,
    input  logic [DATA_W-1:0] rf_rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [AWIDTH-1:0] out_rd,
    output logic              out_use_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q;
    logic [AWIDTH-1:0] rs_q, rt_q, rd_q;
    logic              use_rs_q, use_rt_q, use_rd_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              out_valid_q;

    logic rs_hazard, rt_hazard, hazard, issue, accept;

    assign hazard   = rs_hazard | rt_hazard;
    assign issue    = (state_q == ST_CHECK) & ~hazard;
    assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_OPND) & out_ready);
    assign accept   = in_ready & in_valid;

    regfile_scoreboard #(.AWIDTH(AWIDTH)) u_scoreboard (
        .clk         (clk),
        .clear       (clear),
        .set_en_i    (issue & use_rd_q),
        .set_addr_i  (rd_q),
        .clr_en_i    (wb_valid),
        .clr_addr_i  (wb_addr),
        .rs_use_i    (use_rs_q),
        .rs_addr_i   (rs_q),
        .rt_use_i    (use_rt_q),
        .rt_addr_i   (rt_q),
        .rs_hazard_o (rs_hazard),
        .rt_hazard_o (rt_hazard)
    );

    // Control FSM with latched instruction fields and saturating stall counter.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            use_rs_q    <= 1'b0;
            use_rt_q    <= 1'b0;
            use_rd_q    <= 1'b0;
            stall_cnt_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                rs_q     <= in_rs;
                rt_q     <= in_rt;
                rd_q     <= in_rd;
                use_rs_q <= in_use_rs;
                use_rt_q <= in_use_rt;
                use_rd_q <= in_use_rd;
            end
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (hazard) begin
                        if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                    end else begin
                        state_q     <= ST_OPND;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_OPND: begin
                    if (out_ready) begin
                        state_q     <= in_valid ? ST_CHECK : ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rf_addr_rs = rs_q;
    assign rf_req_rs  = issue & use_rs_q;
    assign rf_addr_rt = rt_q;
    assign rf_req_rt  = issue & use_rt_q;

    // Writeback is a straight pass-through onto the write port.
    assign rf_req_rd  = wb_valid;
    assign rf_addr_rd = wb_addr;
    assign rf_wdata   = wb_data;

    assign out_valid  = out_valid_q;
    assign out_a      = rf_rs;
    assign out_b      = rf_rt;
    assign out_rd     = rd_q;
    assign out_use_rd = use_rd_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/regfile_issue_ctrl.md
Name: regfile_issue_ctrl

Overview:
- Initiator side of the register-file port. Accepts decoded instructions from decode over a valid/ready handshake.
- Tracks pending destination writes in a busy-bit scoreboard and stalls on RAW hazards.
- Issues rs/rt read requests to the register file and presents the returned operands to execute over a second valid/ready handshake.
- Forwards execute writebacks onto the register-file write port and retires their scoreboard bits.

Parameters:
AWIDTH, 8, register address width; the scoreboard has 1<<AWIDTH busy bits.
CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock, all state updates on posedge
clear  in  1  reset, synchronous, active-high
in_valid  in  1  decoded instruction valid
in_ready  out  1  controller can accept an instruction
in_rs  in  AWIDTH  source register A
in_use_rs  in  1  instruction reads rs
in_rt  in  AWIDTH  source register B
in_use_rt  in  1  instruction reads rt
in_rd  in  AWIDTH  destination register
in_use_rd  in  1  instruction writes rd
wb_valid  in  1  execute writeback valid, always accepted
wb_addr  in  AWIDTH  writeback register
wb_data  in  16  writeback value
rf_addr_rs / rf_req_rs  out  AWIDTH / 1  register-file read port A
rf_addr_rt / rf_req_rt  out  AWIDTH / 1  register-file read port B
rf_addr_rd / rf_req_rd / rf_wdata  out  AWIDTH / 1 / 16  register-file write port
rf_rs / rf_rt  in  16 / 16  register-file registered read data
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts operands
out_a / out_b  out  16 / 16  operand values
out_rd / out_use_rd  out  AWIDTH / 1  destination, passed through
stall_cnt  out  CNT_W  cycles spent stalled on hazards

Behaviour:
- Reset: clear=1 at a posedge sets state=IDLE, scoreboard all 0, out_valid=0, stall_cnt=0, and latched fields to 0. Reset wins over every other event, including mid-stall and while out_valid=1 (the pending instruction is dropped).
- Register-file timing: the file writes on negedge and reads into a register on posedge.
  - A write presented in cycle N is visible to a read requested in cycle N.
  - Read data is valid in cycle N+1 and holds until the next request.
- Writeback path is combinational pass-through: rf_req_rd=wb_valid, rf_addr_rd=wb_addr, rf_wdata=wb_data. On the posedge, wb_valid clears busy[wb_addr].
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid, latch all in_* fields and go to CHECK.
  - CHECK:
    - in_ready=0.
    - A hazard exists if (use_rs & busy[rs] & !(wb_valid & wb_addr==rs)), or the same test for rt.
    - On hazard: stay in CHECK and increment stall_cnt, saturating at all-ones.
    - Otherwise:
      - Assert rf_req_rs=use_rs and rf_req_rt=use_rt with the latched addresses.
      - If use_rd, set busy[rd].
      - Go to OPND.
  - OPND:
    - out_valid=1, out_a=rf_rs, out_b=rf_rt, out_rd and out_use_rd from the latched fields.
    - in_ready=out_ready.
    - On out_ready & in_valid: latch the new instruction and go to CHECK.
    - On out_ready & !in_valid: go to IDLE.
    - Otherwise hold; no rf_req is asserted in OPND, so the operands stay stable.
- rf_req_rs/rt are 0 in every state except a non-stalled CHECK cycle.
- Latency: 2 cycles from acceptance to out_valid when there is no hazard.
- Sustained throughput: one instruction per 2 cycles.
- Simultaneous set/clear of the same busy bit (issue with rd==wb_addr): set wins.
- Writeback to a non-busy register is legal; its bit stays 0.
- An instruction whose source equals its own rd checks the old busy state before its own set, so it does not stall on itself.
- Unused sources (use_*=0) are never hazard-checked; out_a/out_b are don't-care.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, CHECK=1, OPND=2);
  - the 16-bit data width constant;
  - the CNT_W default.
- One sub-module, regfile_scoreboard:
  - busy-bit array with set/clear ports and reset;
  - two hazard lookups with the writeback-bypass comparison.

Test Plan:
- No hazard: issue rs=3, rt=4, use_rd=1, rd=5 after reset → rf_req_rs/rt high for exactly 1 cycle; out_valid 2 cycles after acceptance; busy[5]=1.
- RAW stall: instr A writes r5; instr B reads rs=5; no writeback for 4 cycles, then wb_valid with r5=0x00AB → B stays in CHECK for 4 cycles, stall_cnt=4; B issues in the writeback cycle; out_a=0x00AB the next cycle.
- Backpressure: out_ready=0 for 3 cycles in OPND → out_a/out_b/out_rd are stable, no rf_req, in_ready=0; on release, a back-to-back next instruction goes directly to CHECK.
- Set/clear collision: issue with rd=7 in the same cycle as a writeback to r7 → busy[7]=1 afterwards; a following reader of r7 stalls.
- Reset mid-operation: assert clear while stalled and again while out_valid=1 → next cycle state=IDLE, out_valid=0, scoreboard 0, stall_cnt=0.
- Saturation: force a hazard for 70000 cycles with CNT_W=16 → stall_cnt holds 0xFFFF.
